// File: rtl/sdram_read_cache.sv
// Direct-mapped write-through read cache in front of the SDRAM controller.
// One 16-bit word per line; misses and all writes go to SDRAM rebased to zero.
module sdram_read_cache #(
    parameter int          IDX_BITS = 4,
    parameter logic [15:0] BASE     = 16'h4c00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [15:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        cpu_ready,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_busy,
    input  logic        mem_ready
);

    localparam int LINES = 1 << IDX_BITS;
    localparam int TW    = 16 - IDX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MREQ,
        MWAIT,
        DONE
    } state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TW-1:0]         tags [LINES];
    logic [15:0]           data [LINES];
    logic                  flush_pend;
    logic                  op_wr;
    logic [IDX_BITS-1:0]   req_idx;
    logic [TW-1:0]         req_tag;

    logic [IDX_BITS-1:0]   idx;
    logic [TW-1:0]         tag;
    logic                  hit;
    logic [15:0]           off;

    assign idx = cpu_addr[IDX_BITS-1:0];
    assign tag = cpu_addr[15:IDX_BITS];
    assign hit = valid[idx] && (tags[idx] == tag);
    assign off = cpu_addr - BASE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            flush_pend <= 1'b0;
            op_wr      <= 1'b0;
            req_idx    <= '0;
            req_tag    <= '0;
            cpu_rdata  <= '0;
            cpu_busy   <= 1'b0;
            cpu_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            // A flush seen mid-transaction is deferred until we are back in IDLE.
            if (flush && state != IDLE)
                flush_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end else if (cpu_write) begin
                        op_wr     <= 1'b1;
                        req_idx   <= idx;
                        req_tag   <= tag;
                        mem_addr  <= {8'b0, off};
                        mem_wdata <= cpu_wdata;
                        if (hit)
                            data[idx] <= cpu_wdata;
                        mem_write <= 1'b1;
                        cpu_busy  <= 1'b1;
                        state     <= MREQ;
                    end else if (cpu_read) begin
                        op_wr     <= 1'b0;
                        req_idx   <= idx;
                        req_tag   <= tag;
                        mem_addr  <= {8'b0, off};
                        mem_wdata <= cpu_wdata;
                        if (hit) begin
                            cpu_rdata <= data[idx];
                            cpu_ready <= 1'b1;
                            state     <= DONE;
                        end else begin
                            mem_read <= 1'b1;
                            cpu_busy <= 1'b1;
                            state    <= MREQ;
                        end
                    end
                end

                MREQ, MWAIT: begin
                    if (mem_ready) begin
                        if (!op_wr) begin
                            cpu_rdata      <= mem_rdata;
                            data[req_idx]  <= mem_rdata;
                            tags[req_idx]  <= req_tag;
                            valid[req_idx] <= 1'b1;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        cpu_busy  <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= DONE;
                    end else if (state == MREQ && mem_busy) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= MWAIT;
                    end
                end

                DONE: begin
                    // Four-phase: wait for the CPU to drop its request.
                    if (!cpu_read && !cpu_write) begin
                        cpu_ready <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_read_cache.sv
// Self-checking bench for sdram_read_cache with a behavioural SDRAM
// controller model and a read-data scoreboard.
module tb_sdram_read_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_ready;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_busy;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic        rd_op = 1'b0;
    logic        ready_d = 1'b0;

    logic [15:0] sdram [0:255];
    int          lat_cfg = 2;
    bit          fast = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          rd_cycles = 0;
    logic [23:0] last_addr = '0;
    logic [15:0] last_wdata = '0;

    always #5 clk = ~clk;

    sdram_read_cache dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_busy  (cpu_busy),
        .cpu_ready (cpu_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_busy  (mem_busy),
        .mem_ready (mem_ready)
    );

    // SDRAM controller model, stepped on the falling edge
    initial begin
        int          phase;
        int          cnt;
        logic [7:0]  a;
        logic        wr;
        logic [15:0] wd;
        phase = 0;
        cnt = 0;
        a = '0;
        wr = 1'b0;
        wd = '0;
        mem_busy = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++)
            sdram[i] = {8'ha5, i[7:0]};
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_read)
                rd_cycles++;
            if (rst) begin
                phase = 0;
                mem_busy = 1'b0;
            end else if (phase == 0) begin
                if (mem_read || mem_write) begin
                    a = mem_addr[7:0];
                    wr = mem_write;
                    wd = mem_wdata;
                    last_addr = mem_addr;
                    last_wdata = mem_wdata;
                    if (wr) n_wr++;
                    else n_rd++;
                    if (fast) begin
                        mem_ready = 1'b1;
                        if (wr) sdram[a] = wd;
                        else mem_rdata = sdram[a];
                    end else begin
                        mem_busy = 1'b1;
                        cnt = lat_cfg;
                        phase = 1;
                    end
                end
            end else begin
                if (cnt == 0) begin
                    mem_busy = 1'b0;
                    mem_ready = 1'b1;
                    if (wr) sdram[a] = wd;
                    else mem_rdata = sdram[a];
                    phase = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Scoreboard: compare read data when cpu_ready rises
    always @(negedge clk) begin
        if (!rst && cpu_ready && !ready_d && rd_op) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: cpu_ready with no expected read, rdata=%h",
                         cpu_rdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (cpu_rdata !== e) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h expected %h", cpu_rdata, e);
                end
            end
        end
        ready_d <= cpu_ready;
    end

    task automatic xact(input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] e,
                        input int flush_at, input int hold,
                        output int lat, output bit held);
        @(negedge clk);
        if (!wr)
            exp_q.push_back(e);
        cpu_addr = a;
        cpu_wdata = d;
        cpu_write = wr;
        cpu_read = !wr;
        rd_op = !wr;
        lat = 0;
        held = 1'b1;
        checks++;
        forever begin
            @(negedge clk);
            lat++;
            flush = (lat == flush_at);
            if (cpu_ready) break;
            if (lat > 200) begin
                errors++;
                $display("FAIL timeout: addr %h no cpu_ready after %0d cycles",
                         a, lat);
                break;
            end
        end
        flush = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (!cpu_ready) held = 1'b0;
        end
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_rdata, cpu_busy, cpu_ready, mem_addr, mem_wdata,
             mem_read, mem_write} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdata=%h busy=%b ready=%b addr=%h wd=%h rd=%b wr=%b required all 0",
                     cpu_rdata, cpu_busy, cpu_ready, mem_addr, mem_wdata,
                     mem_read, mem_write);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_miss_hit();
        int  lat;
        bit  h;
        int  r0;
        int  c0;
        sdram[8'h05] = 16'hbeef;
        r0 = n_rd;
        c0 = rd_cycles;
        xact(0, 16'h4c05, 16'h0, 16'hbeef, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 + 1 || last_addr !== 24'h000005) begin
            errors++;
            $display("FAIL miss_req: reads %0d addr %h required %0d addr 000005",
                     n_rd - r0, last_addr, 1);
        end
        checks++;
        if (rd_cycles != c0 + 1) begin
            errors++;
            $display("FAIL miss_rd_phase: mem_read cycles %0d required 1",
                     rd_cycles - c0);
        end
        r0 = n_rd;
        xact(0, 16'h4c05, 16'h0, 16'hbeef, 0, 0, lat, h);
        checks++;
        if (lat != 1 || n_rd != r0) begin
            errors++;
            $display("FAIL hit_latency: lat %0d reads %0d required lat 1 reads 0",
                     lat, n_rd - r0);
        end
    endtask

    task automatic test_alias();
        int lat;
        bit h;
        int r0;
        sdram[8'h15] = 16'h1515;
        r0 = n_rd;
        xact(0, 16'h4c15, 16'h0, 16'h1515, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 + 1 || last_addr !== 24'h000015) begin
            errors++;
            $display("FAIL alias_miss: reads %0d addr %h required 1 addr 000015",
                     n_rd - r0, last_addr);
        end
        r0 = n_rd;
        xact(0, 16'h4c05, 16'h0, 16'hbeef, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 + 1) begin
            errors++;
            $display("FAIL alias_evict: reads %0d required 1", n_rd - r0);
        end
    endtask

    task automatic test_write_hit();
        int lat;
        bit h;
        int r0;
        int w0;
        w0 = n_wr;
        xact(1, 16'h4c05, 16'h1234, 16'h0, 0, 0, lat, h);
        checks++;
        if (n_wr != w0 + 1 || last_wdata !== 16'h1234 ||
            last_addr !== 24'h000005) begin
            errors++;
            $display("FAIL write_fwd: writes %0d wdata %h addr %h required 1 1234 000005",
                     n_wr - w0, last_wdata, last_addr);
        end
        r0 = n_rd;
        xact(0, 16'h4c05, 16'h0, 16'h1234, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 || lat != 1) begin
            errors++;
            $display("FAIL write_update: reads %0d lat %0d required 0 1",
                     n_rd - r0, lat);
        end
    endtask

    task automatic test_no_alloc();
        int lat;
        bit h;
        int r0;
        xact(1, 16'h4c07, 16'h7777, 16'h0, 0, 0, lat, h);
        r0 = n_rd;
        xact(0, 16'h4c07, 16'h0, 16'h7777, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 + 1 || last_addr !== 24'h000007) begin
            errors++;
            $display("FAIL no_alloc: reads %0d addr %h required 1 000007",
                     n_rd - r0, last_addr);
        end
    endtask

    task automatic test_flush();
        int lat;
        bit h;
        int r0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        r0 = n_rd;
        xact(0, 16'h4c05, 16'h0, 16'h1234, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 + 1) begin
            errors++;
            $display("FAIL flush_idle: reads %0d required 1", n_rd - r0);
        end
        lat_cfg = 5;
        sdram[8'h09] = 16'h0909;
        xact(0, 16'h4c09, 16'h0, 16'h0909, 3, 0, lat, h);
        r0 = n_rd;
        xact(0, 16'h4c09, 16'h0, 16'h0909, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 + 1) begin
            errors++;
            $display("FAIL flush_deferred: reads %0d required 1", n_rd - r0);
        end
        lat_cfg = 2;
    endtask

    task automatic test_hold();
        int lat;
        bit h;
        int r0;
        int w0;
        r0 = n_rd;
        w0 = n_wr;
        xact(0, 16'h4c09, 16'h0, 16'h0909, 0, 10, lat, h);
        checks++;
        if (!h || n_rd != r0 || n_wr != w0 || lat != 1) begin
            errors++;
            $display("FAIL hold_request: held %b reads %0d writes %0d lat %0d required 1 0 0 1",
                     h, n_rd - r0, n_wr - w0, lat);
        end
    endtask

    task automatic test_fast_ready();
        int lat;
        bit h;
        int r0;
        fast = 1'b1;
        r0 = n_rd;
        xact(0, 16'h4c0a, 16'h0, 16'ha50a, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 + 1 || last_addr !== 24'h00000a) begin
            errors++;
            $display("FAIL fast_ready: reads %0d addr %h required 1 00000a",
                     n_rd - r0, last_addr);
        end
        fast = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit h;
        int r0;
        lat_cfg = 6;
        @(negedge clk);
        cpu_addr = 16'h4c0b;
        cpu_read = 1'b1;
        rd_op = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (!cpu_busy || mem_read) begin
            errors++;
            $display("FAIL mwait_state: busy %b mem_read %b required 1 0",
                     cpu_busy, mem_read);
        end
        rst = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_rdata, cpu_busy, cpu_ready, mem_addr, mem_wdata,
             mem_read, mem_write} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b ready=%b addr=%h rd=%b wr=%b required all 0",
                     cpu_busy, cpu_ready, mem_addr, mem_read, mem_write);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        lat_cfg = 2;
        r0 = n_rd;
        xact(0, 16'h4c09, 16'h0, 16'h0909, 0, 0, lat, h);
        checks++;
        if (n_rd != r0 + 1) begin
            errors++;
            $display("FAIL reset_empty: reads %0d required 1", n_rd - r0);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        test_reset();
        test_miss_hit();
        test_alias();
        test_write_hit();
        test_no_alloc();
        test_flush();
        test_hold();
        test_fast_ready();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d reads outstanding required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
